// File: rtl/sdram_write.sv
// SDRAM write engine: fills rows 0..END_ROW with 4-word bursts and yields to refresh.
// Define SDRAM_WR_PATTERN_EN to source write data from an internal counter.
module sdram_write #(
    parameter int unsigned END_ROW = 2
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        ref_req,
    output logic        wr_req,
    output logic        flag_wr_end,
    output logic [3:0]  wr_cmd,
    output logic [11:0] wr_addr,
    output logic [1:0]  bank_addr,
    output logic [15:0] wr_data,
    input  logic [15:0] fifo_dout,
    output logic        fifo_rd
);

    localparam logic [3:0]  CmdNop  = 4'b0111;
    localparam logic [3:0]  CmdAct  = 4'b0011;
    localparam logic [3:0]  CmdWr   = 4'b0100;
    localparam logic [3:0]  CmdPre  = 4'b0010;
    localparam logic [8:0]  LastCol = 9'd508;
    localparam logic [11:0] LastRow = 12'(END_ROW);

    typedef enum logic [4:0] {
        StIdle = 5'b00001,
        StReq  = 5'b00010,
        StAct  = 5'b00100,
        StWr   = 5'b01000,
        StPre  = 5'b10000
    } state_e;

    // Where to go once the precharge window has elapsed.
    typedef enum logic [1:0] {
        ExitIdle,
        ExitReq,
        ExitAct
    } exit_e;

    state_e      state_q, state_d;
    exit_e       exit_q, exit_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [8:0]  col_q, col_d;
    logic [11:0] row_q, row_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] data_q;
    logic        flag_q, flag_d;
    logic        last_burst;
    logic        take_word;
    logic [15:0] word_src;

    assign last_burst = (row_q == LastRow) && (col_q == LastCol);

    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        cmd_d   = CmdNop;
        addr_d  = '0;
        flag_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_trig) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = 2'd0;
                if (wr_en) begin
                    state_d = StAct;
                end
            end
            StAct: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StWr;
                end
            end
            StWr: begin
                cnt_d = cnt_q + 2'd1;
                // Bursts are never cut short; everything is decided on the last beat.
                if (cnt_q == 2'd3) begin
                    col_d = col_q + 9'd4;
                    if (last_burst) begin
                        state_d = StPre;
                        exit_d  = ExitIdle;
                        row_d   = '0;
                    end else begin
                        if (col_q == LastCol) begin
                            row_d = row_q + 12'd1;
                        end
                        if (ref_req) begin
                            state_d = StPre;
                            exit_d  = ExitReq;
                        end else if (col_q == LastCol) begin
                            state_d = StPre;
                            exit_d  = ExitAct;
                        end
                    end
                end
            end
            StPre: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    unique case (exit_q)
                        ExitIdle: state_d = StIdle;
                        ExitReq:  state_d = StReq;
                        default:  state_d = StAct;
                    endcase
                    flag_d = (exit_q != ExitAct);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Commands are registered alongside the state they belong to.
        if (cnt_d == 2'd0) begin
            case (state_d)
                StAct: begin
                    cmd_d  = CmdAct;
                    addr_d = row_d;
                end
                StWr: begin
                    cmd_d  = CmdWr;
                    addr_d = {3'b000, col_d};
                end
                StPre: begin
                    cmd_d  = CmdPre;
                    addr_d = 12'h400;
                end
                default: ;
            endcase
        end
    end

    assign take_word = (state_d == StWr) && !s_rst;

`ifdef SDRAM_WR_PATTERN_EN
    logic [15:0] pat_q;
    logic        unused_fifo;

    assign unused_fifo = ^fifo_dout;
    assign word_src    = pat_q;
    assign fifo_rd     = 1'b0;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            pat_q <= '0;
        end else if (take_word) begin
            pat_q <= pat_q + 16'd1;
        end
    end
`else
    // Show-ahead FIFO: the pop and the capture share the same edge.
    assign word_src = fifo_dout;
    assign fifo_rd  = take_word;
`endif

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q <= StIdle;
            exit_q  <= ExitIdle;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            flag_q  <= flag_d;
            if (take_word) begin
                data_q <= word_src;
            end
        end
    end

    assign wr_req      = (state_q == StReq);
    assign flag_wr_end = flag_q;
    assign wr_cmd      = cmd_q;
    assign wr_addr     = addr_q;
    assign bank_addr   = 2'b00;
    assign wr_data     = data_q;

endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: reset/start-up vector table, directed refresh and reset corner
// cases, then randomized grant/refresh traffic against a transaction-level scoreboard.
module tb_sdram_write;

    localparam int unsigned EndRow = 2;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
`ifdef SDRAM_WR_PATTERN_EN
    localparam bit FifoOn = 1'b0;
`else
    localparam bit FifoOn = 1'b1;
`endif

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        wr_trig = 1'b0;
    logic        wr_en = 1'b0;
    logic        ref_req = 1'b0;
    logic        wr_req, flag_wr_end, fifo_rd;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  bank_addr;
    logic [15:0] wr_data, fifo_dout;

    sdram_write #(.END_ROW(EndRow)) dut (
        .sclk        (sclk),
        .s_rst       (s_rst),
        .wr_trig     (wr_trig),
        .wr_en       (wr_en),
        .ref_req     (ref_req),
        .wr_req      (wr_req),
        .flag_wr_end (flag_wr_end),
        .wr_cmd      (wr_cmd),
        .wr_addr     (wr_addr),
        .bank_addr   (bank_addr),
        .wr_data     (wr_data),
        .fifo_dout   (fifo_dout),
        .fifo_rd     (fifo_rd)
    );

    initial forever #5 sclk = ~sclk;

    // Show-ahead source FIFO preloaded with random words.
    logic [15:0] fifo_mem [4096];
    logic [11:0] rd_ptr = '0;
    assign fifo_dout = fifo_mem[rd_ptr];
    always @(posedge sclk) if (fifo_rd) rd_ptr <= rd_ptr + 12'd1;

    int checks = 0;
    int errors = 0;

    // Scoreboard state: next (row, col) to be written, cycles since each command.
    int          sb_row, sb_col, burst_ph, act_ph, pre_ph, pre_tgt;
    bit          sb_idle, prev_req;
    logic [11:0] exp_ptr;
    logic [15:0] exp_pat, last_data;
    int          cnt_wr, cnt_act, cnt_pre, cnt_flag, done_cnt;
    bit          edge_ref, edge_rst, edge_trig, edge_en;

    typedef struct {
        bit          trig;
        bit          en;
        logic [3:0]  cmd;
        logic [11:0] addr;
        bit          chk_addr;
        bit          req;
        bit          rd;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic sb_clear();
        sb_row = 0; sb_col = 0;
        burst_ph = -1; act_ph = -1; pre_ph = -1; pre_tgt = 0;
        sb_idle = 1'b1; prev_req = 1'b0;
        exp_ptr = rd_ptr; exp_pat = '0; last_data = '0;
    endtask

    task automatic sb_sample();
        logic [3:0] exp_c;
        bit exp_req, exp_flag, last, rowend;
        if (edge_rst) begin
            sb_clear();
            return;
        end
        exp_c = NOP; exp_req = 1'b0; exp_flag = 1'b0;
        if (burst_ph >= 0) burst_ph++;
        if (act_ph >= 0) act_ph++;
        if (pre_ph >= 0) pre_ph++;

        if (sb_idle) begin
            if (edge_trig) begin
                exp_req = 1'b1;
                sb_idle = 1'b0;
            end
        end else if (prev_req) begin
            if (edge_en) exp_c = ACT;
            else exp_req = 1'b1;
        end

        if (burst_ph == 4) begin
            burst_ph = -1;
            last   = (sb_row == EndRow) && (sb_col == 508);
            rowend = (sb_col == 508);
            if (last) begin
                sb_row = 0; sb_col = 0; pre_tgt = 2; exp_c = PRE;
            end else begin
                if (rowend) begin
                    sb_row++; sb_col = 0;
                end else begin
                    sb_col += 4;
                end
                if (edge_ref) begin
                    pre_tgt = 1; exp_c = PRE;
                end else if (rowend) begin
                    pre_tgt = 0; exp_c = PRE;
                end else begin
                    exp_c = WR;
                end
            end
        end
        if (pre_ph == 4) begin
            pre_ph = -1;
            if (pre_tgt == 0) begin
                exp_c = ACT;
            end else begin
                exp_flag = 1'b1;
                exp_req  = (pre_tgt == 1);
                if (pre_tgt == 2) begin
                    sb_idle = 1'b1;
                    done_cnt++;
                end
            end
        end
        if (act_ph == 4) begin
            act_ph = -1;
            exp_c = WR;
        end

        chk("cmd", wr_cmd, exp_c);
        chk("wr_req", wr_req, exp_req);
        chk("flag_wr_end", flag_wr_end, exp_flag);
        chk("bank_addr", bank_addr, 0);
        if (flag_wr_end) cnt_flag++;
        case (wr_cmd)
            ACT: begin chk("act_row", wr_addr, sb_row); act_ph = 0; cnt_act++; end
            WR:  begin chk("wr_col", wr_addr, sb_col); burst_ph = 0; cnt_wr++; end
            PRE: begin chk("pre_addr", wr_addr, 12'h400); pre_ph = 0; cnt_pre++; end
            default: ;
        endcase
        if (burst_ph >= 0 && burst_ph <= 3) begin
`ifdef SDRAM_WR_PATTERN_EN
            last_data = exp_pat;
            exp_pat++;
`else
            last_data = fifo_mem[exp_ptr];
            exp_ptr++;
            chk("fifo_pops", rd_ptr, exp_ptr);
`endif
        end
        chk("wr_data", wr_data, last_data);
`ifdef SDRAM_WR_PATTERN_EN
        chk("fifo_rd_idle", fifo_rd, 0);
`endif
        prev_req = exp_req;
    endtask

    // Capture the inputs the DUT sees at the edge, then sample outputs mid-cycle.
    task automatic tick();
        @(posedge sclk);
        edge_ref = ref_req; edge_rst = s_rst; edge_trig = wr_trig; edge_en = wr_en;
        @(negedge sclk);
        sb_sample();
    endtask

    task automatic wait_cmd(input logic [3:0] c, input bit match, input logic [11:0] a,
                            input string name, output logic [11:0] got);
        int n = 0;
        got = '0;
        while (!(wr_cmd == c && (!match || wr_addr == a))) begin
            tick();
            n++;
            if (n > 4000) begin
                checks++; errors++;
                $display("FAIL %s: timeout, got cmd %b, expected cmd %b", name, wr_cmd, c);
                return;
            end
        end
        got = wr_addr;
    endtask

    task automatic wait_flag(input string name);
        int n = 0;
        while (flag_wr_end !== 1'b1) begin
            tick();
            n++;
            if (n > 4000) begin
                checks++; errors++;
                $display("FAIL %s: timeout, got flag_wr_end 0, expected 1", name);
                return;
            end
        end
    endtask

    task automatic run_until_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 4000) begin
            tick();
            n++;
        end
        chk(name, done_cnt, target);
    endtask

    task automatic pulse_trig();
        wr_trig = 1'b1;
        tick();
        wr_trig = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd"}, wr_cmd, NOP);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_req"}, wr_req, 0);
        chk({tag, "_rd"}, fifo_rd, 0);
        chk({tag, "_flag"}, flag_wr_end, 0);
    endtask

    initial begin
        logic [11:0] got;
        int hold;
        for (int i = 0; i < 4096; i++) fifo_mem[i] = 16'($urandom);
        vecs[0]  = '{1'b1, 1'b0, NOP, 12'h000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, NOP, 12'h000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, ACT, 12'h000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, WR,  12'h000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, WR,  12'h004, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, NOP, 12'h000, 1'b0, 1'b0, 1'b1};

        s_rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        s_rst = 1'b0;

        // Start-up sequence and full uninterrupted transfer.
        cnt_wr = 0; cnt_act = 0; cnt_pre = 0; cnt_flag = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            wr_trig = vecs[i].trig;
            wr_en   = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_cmd", i), wr_cmd, vecs[i].cmd);
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), wr_addr, vecs[i].addr);
            chk($sformatf("vec%0d_req", i), wr_req, vecs[i].req);
            chk($sformatf("vec%0d_rd", i), fifo_rd, vecs[i].rd & FifoOn);
        end
        wr_trig = 1'b0;
        wr_en   = 1'b1;
        run_until_done(1, "full_done");
        chk("full_wr_count", cnt_wr, 384);
        chk("full_act_count", cnt_act, 3);
        chk("full_pre_count", cnt_pre, 3);
        chk("full_flag_count", cnt_flag, 1);

        // Refresh mid-row, at row end, and at the final burst.
        cnt_flag = 0; done_cnt = 0;
        pulse_trig();
        wait_cmd(WR, 1'b1, 12'd16, "wait_col16", got);
        tick();
        ref_req = 1'b1;
        wait_flag("ref_mid_flag");
        ref_req = 1'b0;
        wait_cmd(ACT, 1'b0, 12'd0, "resume_act", got);
        chk("resume_row", got, 0);
        wait_cmd(WR, 1'b0, 12'd0, "resume_wr", got);
        chk("resume_col", got, 20);

        wait_cmd(WR, 1'b1, 12'd508, "wait_row0_end", got);
        tick();
        ref_req = 1'b1;
        wait_flag("ref_rowend_flag");
        ref_req = 1'b0;
        wait_cmd(ACT, 1'b0, 12'd0, "rowend_act", got);
        chk("rowend_next_row", got, 1);
        wait_cmd(WR, 1'b0, 12'd0, "rowend_wr", got);
        chk("rowend_col", got, 0);

        wait_cmd(ACT, 1'b1, 12'd2, "wait_row2", got);
        wait_cmd(WR, 1'b1, 12'd508, "wait_final", got);
        tick();
        ref_req = 1'b1;
        wait_flag("final_flag");
        ref_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("final_no_req", wr_req, 0);
        end
        chk("final_done", done_cnt, 1);
        chk("ref_flag_count", cnt_flag, 3);

        // Reset in the middle of a burst, then restart from the top.
        pulse_trig();
        wait_cmd(WR, 1'b1, 12'd100, "wait_col100", got);
        tick();
        s_rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        s_rst = 1'b0;
        pulse_trig();
        wait_cmd(ACT, 1'b0, 12'd0, "restart_act", got);
        chk("restart_row", got, 0);
        wait_cmd(WR, 1'b0, 12'd0, "restart_wr", got);
        chk("restart_col", got, 0);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;

        // Randomized grants, refresh requests and stray triggers.
        done_cnt = 0;
        hold = 0;
        for (int c = 0; c < 12000 && done_cnt < 2; c++) begin
            wr_en = ($urandom_range(0, 3) != 0);
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                ref_req = 1'b1;
                hold = $urandom_range(1, 10);
            end else begin
                ref_req = 1'b0;
            end
            wr_trig = sb_idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            tick();
        end
        wr_trig = 1'b0;
        ref_req = 1'b0;
        chk("random_transfers", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_write.md
SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 Parameter: END_ROW, default 2, last row address written in one transfer (rows 0..END_ROW, full 512 columns each).
REQ-002 Port: sclk  input  1  system clock; all logic on rising edge.
REQ-003 Port: s_rst  input  1  reset; one clock, synchronous and active-high.
REQ-004 Port: wr_trig  input  1  one-cycle pulse starting a transfer.
REQ-005 Port: wr_en  input  1  arbiter grant of the SDRAM command bus.
REQ-006 Port: ref_req  input  1  refresh request from the refresh block.
REQ-007 Port: wr_req  output  1  bus request to arbiter.
REQ-008 Port: flag_wr_end  output  1  one-cycle pulse: bus released.
REQ-009 Port: wr_cmd  output  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, WR 0100, PRE 0010.
REQ-010 Port: wr_addr  output  12  SDRAM address (row on ACT, {000,col} on WR, 12'h400 on PRE).
REQ-011 Port: bank_addr  output  2  constant 2'b00.
REQ-012 Port: wr_data  output  16  SDRAM DQ write data.
REQ-013 Port: fifo_dout  input  16  show-ahead source FIFO data.
REQ-014 Port: fifo_rd  output  1  FIFO pop, high in the cycle fifo_dout is captured.

Function
REQ-015 States IDLE, REQ, ACT, WR, PRE; one-hot encoded.
REQ-016 IDLE->REQ on wr_trig; wr_trig outside IDLE ignored.
REQ-017 REQ: wr_req=1; REQ->ACT when wr_en=1; wr_req is 0 in all other states.
REQ-018 ACT lasts 4 cycles: ACT with wr_addr=row on cycle 0, NOP on cycles 1-3 (tRCD), then ->WR.
REQ-019 WR issues 4-cycle bursts: WR command with wr_addr={000,col} on burst cycle 0, NOP on 1-3; col advances by 4 per burst.
REQ-020 wr_data carries one FIFO word every WR cycle, aligned with wr_cmd/wr_addr (all registered, same edge); fifo_rd high once per word, exactly 4 per burst.
REQ-021 Decision only at burst cycle 3: last burst of END_ROW (col 508) ->PRE then IDLE; else ref_req=1 ->PRE then REQ; else col 508 ->PRE then ACT with row+1, col 0; else next burst.
REQ-022 PRE lasts 4 cycles: PRE with wr_addr=12'h400 (A10 all banks) on cycle 0, NOP on 1-3 (tRP).
REQ-023 flag_wr_end pulses for one cycle on the PRE-exit edge going to REQ or IDLE; never when going to ACT.
REQ-024 ref_req during a burst never truncates it; burst completes before PRE.
REQ-025 After refresh preemption, resumed ACT uses the same row; WR resumes at the next unwritten column.
REQ-026 ref_req coincident with row end: single PRE, ->REQ; resumed ACT uses row+1, col 0.
REQ-027 ref_req coincident with final burst: final path wins, ->IDLE, one flag_wr_end pulse.
REQ-028 Column is 9 bits, wraps 508+4 -> 0; row is 12 bits and resets to 0 at end of transfer.
REQ-029 wr_cmd=NOP in IDLE and REQ; wr_data holds last value outside WR.

Reset
REQ-030 s_rst=1 on any edge, including mid-burst: state=IDLE, wr_cmd=NOP, wr_addr=0, wr_data=0, wr_req=0, fifo_rd=0, flag_wr_end=0, row=0, col=0, all counters 0.
REQ-031 No flag_wr_end pulse is generated by reset.

Configuration
REQ-032 Macro SDRAM_WR_PATTERN_EN defined: FIFO ignored, fifo_rd held 0, wr_data = internal 16-bit counter, reset 0, incrementing per written word.
REQ-033 Macro undefined: wr_data sourced from fifo_dout per REQ-020; no pattern counter present.

Verification
REQ-034 Reset, wr_trig, wr_en held 1, ref_req 0 -> ACT row 0, 128 WR commands col 0,4,..508, PRE, ACT row 1 ... row 2 col 508, PRE, one flag_wr_end, IDLE.
REQ-035 ref_req at burst cycle 1 of col 16 -> burst finishes (4 words), PRE, flag_wr_end, REQ; grant -> ACT same row, next WR col 20.
REQ-036 ref_req at row 0 col 508 burst -> PRE, REQ; after grant ACT wr_addr=1, WR col 0.
REQ-037 ref_req at final burst (row 2 col 508) -> IDLE, exactly one flag_wr_end, no REQ.
REQ-038 s_rst during WR at col 100 -> next cycle NOP, IDLE, outputs 0; new wr_trig restarts row 0 col 0.
REQ-039 SDRAM_WR_PATTERN_EN defined, full transfer -> wr_data 0,1,2..1535 across 3 rows, fifo_rd never 1.
